// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Pixel-stream sequencer between the game FSM and the VGA adapter. A start
//   pulse walks a rectangular region one pixel per clock, issuing ROM
//   addresses and one plot strobe per visible pixel.
//   Modes: 00 draw sprite at (px,py), 01 erase sprite footprint from the
//   background ROM, 10 redraw full background, 11 reserved (no plots).
//
// Handshake: start is sampled only in IDLE; busy is high from the cycle after
//   start until the last plot; done is a one-cycle pulse the cycle after that.
//   There is no back-pressure: the VGA adapter must accept plot every cycle.
//
// Pipeline: stage 1 registers rom_addr for pixel k (cycle k+1); stage 2
//   registers vga_x/vga_y and the plot qualifier (cycle k+2), aligned with
//   the 1-cycle ROM latency, so colour is simply rom_data.
//
// Optional macro: TRANSPARENCY_EN -- in sprite mode, pixels whose colour
//   equals TRANSP_KEY are not plotted.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start, mode, px, py   request, mode, sprite top-left (latched at start)
//   rom_data              colour from selected ROM (1-cycle latency)
//   rom_addr, rom_sel     ROM address, 0 = sprite ROM, 1 = background ROM
//   vga_x, vga_y, colour  pixel coordinate and colour
//   plot                  VGA write strobe
//   busy, done            transfer in progress / completion pulse
//   dbg_state             current FSM state (0 IDLE, 1 RUN, 2 DONE)
module sprite_blitter #(
  parameter int SPR_W   = 12,
  parameter int SPR_H   = 16,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120,
  parameter int COORD_W = 8,
  parameter int ADDR_W  = 15,
  parameter int COL_W   = 3,
  parameter logic [COL_W-1:0] TRANSP_KEY = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COL_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_sel,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [COL_W-1:0]   colour,
  output logic               plot,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] M_SPR   = 2'b00;
  localparam logic [1:0] M_ERASE = 2'b01;
  localparam logic [1:0] M_BG    = 2'b10;
  localparam logic [1:0] M_RSV   = 2'b11;

  localparam logic [COORD_W:0] SCR_W_C = (COORD_W+1)'(SCR_W);
  localparam logic [COORD_W:0] SCR_H_C = (COORD_W+1)'(SCR_H);

  state_t state_q, state_d;
  logic [1:0]         mode_q;
  logic [COORD_W-1:0] px_q, py_q, col_q, row_q, col_d, row_d;

  // Mode/origin used for the address of the next pixel: the live inputs on
  // the start edge, the latched copies afterwards.
  logic [1:0]         m_cur;
  logic [COORD_W-1:0] px_cur, py_cur, w_last, h_last;
  logic               last_px;
  logic [ADDR_W-1:0]  addr_d;
  logic [COORD_W:0]   sx, sy;
  logic               vis;
  logic               plot_q, spr_q;

  always_comb begin
    m_cur   = (state_q == S_IDLE) ? mode : mode_q;
    px_cur  = (state_q == S_IDLE) ? px   : px_q;
    py_cur  = (state_q == S_IDLE) ? py   : py_q;
    w_last  = (m_cur == M_BG) ? COORD_W'(SCR_W - 1) : COORD_W'(SPR_W - 1);
    h_last  = (m_cur == M_BG) ? COORD_W'(SCR_H - 1) : COORD_W'(SPR_H - 1);
    last_px = (col_q == w_last) && (row_q == h_last);

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          state_d = (mode == M_RSV) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_px) begin
          state_d = S_DONE;
        end else if (col_q == w_last) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address of the pixel that will be current after this edge.
    if (m_cur == M_ERASE)
      addr_d = ADDR_W'((32'(py_cur) + 32'(row_d)) * 32'(SCR_W)
                       + 32'(px_cur) + 32'(col_d));
    else
      addr_d = ADDR_W'(32'(row_d) * (32'(w_last) + 32'd1) + 32'(col_d));

    // Screen position of the current pixel; one extra bit catches the carry
    // out of COORD_W so wrapped coordinates are clipped, not plotted.
    if (mode_q == M_BG) begin
      sx = {1'b0, col_q};
      sy = {1'b0, row_q};
    end else begin
      sx = {1'b0, px_q} + {1'b0, col_q};
      sy = {1'b0, py_q} + {1'b0, row_q};
    end
    vis = (sx < SCR_W_C) && (sy < SCR_H_C);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mode_q   <= M_SPR;
      px_q     <= '0;
      py_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      rom_addr <= '0;
      rom_sel  <= 1'b0;
      vga_x    <= '0;
      vga_y    <= '0;
      plot_q   <= 1'b0;
      spr_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (state_q == S_IDLE && start) begin
        mode_q   <= mode;
        px_q     <= px;
        py_q     <= py;
        rom_sel  <= (mode == M_ERASE) || (mode == M_BG);
        rom_addr <= addr_d;
        busy     <= 1'b1;
      end else if (state_q == S_RUN) begin
        rom_addr <= addr_d;
      end
      // Stage 2: coordinates and qualifier of the pixel now on rom_addr.
      plot_q <= (state_q == S_RUN) && vis;
      spr_q  <= (mode_q == M_SPR);
      if (state_q == S_RUN) begin
        vga_x <= sx[COORD_W-1:0];
        vga_y <= sy[COORD_W-1:0];
      end
      if (state_q == S_DONE) busy <= 1'b0;
      done <= (state_q == S_DONE);
    end
  end

  assign colour    = rom_data;
  assign dbg_state = state_q;

`ifdef TRANSPARENCY_EN
  assign plot = plot_q & (~spr_q | (rom_data != TRANSP_KEY));
`else
  assign plot = plot_q;
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

`ifdef TRANSPARENCY_EN
  localparam int SPR_PLOTS  = 180;
  localparam int FIRST_SY   = 21;
  localparam int CLIP_PLOTS = 45;
`else
  localparam int SPR_PLOTS  = 192;
  localparam int FIRST_SY   = 20;
  localparam int CLIP_PLOTS = 50;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  px = 8'd0, py = 8'd0;
  logic [2:0]  rom_data = 3'd0;
  logic [14:0] rom_addr;
  logic        rom_sel;
  logic [7:0]  vga_x, vga_y;
  logic [2:0]  colour;
  logic        plot, busy, done;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int fails = 0;

  // Results of the last transfer
  int n_plots, first_x, first_y, last_x, last_y, first_cyc, last_cyc;
  int min_x, max_x, max_y, done_cyc, done_cnt, busy_cnt, busy_first, busy_last;
  int col_err;
  logic [14:0] addr_c1, addr_probe;
  logic        sel_c1;

  sprite_blitter dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .px(px), .py(py),
    .rom_data(rom_data), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- ROM models (1-cycle synchronous)
  function automatic logic [2:0] spr_fn(input int a);
    if (a < 12) return 3'd0;
    return 3'((a % 7) + 1);
  endfunction

  function automatic logic [2:0] bg_fn(input int a);
    return 3'(a % 8);
  endfunction

  always @(posedge clk) rom_data <= rom_sel ? bg_fn(int'(rom_addr)) : spr_fn(int'(rom_addr));

  // ---------------- driver: one transfer, recorded cycle by cycle
  // Cycle c is the interval after the c-th edge counted from the start edge.
  task automatic run_xfer(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                          input int probe_cyc, input int poke_cyc, input int budget);
    int ea;
    n_plots = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    busy_cnt = 0; busy_first = -1; busy_last = -1; col_err = 0;
    min_x = 999; max_x = -1; max_y = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    addr_c1 = '0; addr_probe = '0; sel_c1 = 1'b0;
    @(negedge clk);
    mode = m; px = x; py = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (c == 1) begin addr_c1 = rom_addr; sel_c1 = rom_sel; end
      if (c == probe_cyc) addr_probe = rom_addr;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (plot) begin
        n_plots++;
        if (first_cyc < 0) begin first_cyc = c; first_x = vga_x; first_y = vga_y; end
        last_cyc = c; last_x = vga_x; last_y = vga_y;
        if (int'(vga_x) < min_x) min_x = vga_x;
        if (int'(vga_x) > max_x) max_x = vga_x;
        if (int'(vga_y) > max_y) max_y = vga_y;
        if (m == 2'b00) begin
          ea = (int'(vga_y) - int'(y)) * 12 + (int'(vga_x) - int'(x));
          if (colour !== spr_fn(ea)) col_err++;
        end else begin
          ea = int'(vga_y) * 160 + int'(vga_x);
          if (colour !== bg_fn(ea)) col_err++;
        end
      end
      if (done) begin done_cyc = c; done_cnt++; end
      if (c == poke_cyc) begin start = 1'b1; mode = 2'b10; end
    end
  endtask

  // ---------------- tests
  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rom_addr, rom_sel, vga_x, vga_y, plot, busy, done, dbg_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%0d sel=%0d x=%0d y=%0d plot=%0d busy=%0d done=%0d st=%0d, all must be 0",
               rom_addr, rom_sel, vga_x, vga_y, plot, busy, done, dbg_state);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sprite;
    run_xfer(2'b00, 8'd10, 8'd20, 192, -1, 400);
    tests_run++;
    if (n_plots !== SPR_PLOTS) begin fails++; $display("FAIL sprite_plots: got %0d want %0d", n_plots, SPR_PLOTS); end
    tests_run++;
    if (first_x !== 10 || first_y !== FIRST_SY) begin fails++; $display("FAIL sprite_first: got (%0d,%0d) want (10,%0d)", first_x, first_y, FIRST_SY); end
    tests_run++;
    if (last_x !== 21 || last_y !== 35 || last_cyc !== 193) begin fails++; $display("FAIL sprite_last: got (%0d,%0d)@%0d want (21,35)@193", last_x, last_y, last_cyc); end
    tests_run++;
    if (addr_c1 !== 15'd0 || sel_c1 !== 1'b0) begin fails++; $display("FAIL sprite_addr0: got %0d sel %0d want 0 sel 0", addr_c1, sel_c1); end
    tests_run++;
    if (addr_probe !== 15'd191) begin fails++; $display("FAIL sprite_addr_last: got %0d want 191", addr_probe); end
    tests_run++;
    if (done_cyc !== 194 || done_cnt !== 1) begin fails++; $display("FAIL sprite_done: got cycle %0d count %0d want 194 x1", done_cyc, done_cnt); end
    tests_run++;
    if (busy_first !== 1 || busy_last !== 193 || busy_cnt !== 193) begin
      fails++; $display("FAIL sprite_busy: got %0d..%0d (%0d) want 1..193 (193)", busy_first, busy_last, busy_cnt);
    end
    tests_run++;
    if (col_err !== 0) begin fails++; $display("FAIL sprite_colour: got %0d bad pixels want 0", col_err); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      fails++; $display("FAIL sprite_after: got done=%0d busy=%0d st=%0d want 0 0 0", done, busy, dbg_state);
    end
  endtask

  task automatic test_erase;
    run_xfer(2'b01, 8'd10, 8'd20, 13, -1, 400);
    tests_run++;
    if (addr_c1 !== 15'd3210 || sel_c1 !== 1'b1) begin fails++; $display("FAIL erase_addr0: got %0d sel %0d want 3210 sel 1", addr_c1, sel_c1); end
    tests_run++;
    if (addr_probe !== 15'd3370) begin fails++; $display("FAIL erase_row1: got %0d want 3370", addr_probe); end
    tests_run++;
    if (n_plots !== 192 || done_cyc !== 194) begin fails++; $display("FAIL erase_plots: got %0d done@%0d want 192 done@194", n_plots, done_cyc); end
    tests_run++;
    if (col_err !== 0) begin fails++; $display("FAIL erase_colour: got %0d bad pixels want 0", col_err); end
  endtask

  task automatic test_background;
    run_xfer(2'b10, 8'd33, 8'd44, 19200, -1, 19400);
    tests_run++;
    if (n_plots !== 19200) begin fails++; $display("FAIL bg_plots: got %0d want 19200", n_plots); end
    tests_run++;
    if (first_x !== 0 || first_y !== 0 || last_x !== 159 || last_y !== 119) begin
      fails++; $display("FAIL bg_span: got (%0d,%0d)..(%0d,%0d) want (0,0)..(159,119)", first_x, first_y, last_x, last_y);
    end
    tests_run++;
    if (addr_c1 !== 15'd0 || addr_probe !== 15'd19199 || sel_c1 !== 1'b1) begin
      fails++; $display("FAIL bg_addr: got %0d..%0d sel %0d want 0..19199 sel 1", addr_c1, addr_probe, sel_c1);
    end
    tests_run++;
    if (done_cyc !== 19202) begin fails++; $display("FAIL bg_done: got %0d want 19202", done_cyc); end
    tests_run++;
    if (col_err !== 0) begin fails++; $display("FAIL bg_colour: got %0d bad pixels want 0", col_err); end
  endtask

  task automatic test_clip;
    run_xfer(2'b00, 8'd155, 8'd110, -1, -1, 400);
    tests_run++;
    if (n_plots !== CLIP_PLOTS) begin fails++; $display("FAIL clip_plots: got %0d want %0d", n_plots, CLIP_PLOTS); end
    tests_run++;
    if (min_x !== 155 || max_x !== 159 || max_y !== 119) begin
      fails++; $display("FAIL clip_bounds: got x %0d..%0d ymax %0d want x 155..159 ymax 119", min_x, max_x, max_y);
    end
    tests_run++;
    if (done_cyc !== 194) begin fails++; $display("FAIL clip_done: got %0d want 194", done_cyc); end
    // Wrap past 255: only x 250..255 would fit 8 bits, all are off-screen.
    run_xfer(2'b00, 8'd250, 8'd250, -1, -1, 400);
    tests_run++;
    if (n_plots !== 0 || done_cyc !== 194) begin fails++; $display("FAIL clip_wrap: got %0d plots done@%0d want 0 done@194", n_plots, done_cyc); end
  endtask

  task automatic test_reserved;
    run_xfer(2'b11, 8'd10, 8'd20, -1, -1, 20);
    tests_run++;
    if (n_plots !== 0 || done_cyc !== 2 || busy_cnt !== 1) begin
      fails++; $display("FAIL reserved: got %0d plots done@%0d busy %0d want 0 done@2 busy 1", n_plots, done_cyc, busy_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done, seen_plot;
    @(negedge clk);
    mode = 2'b00; px = 8'd10; py = 8'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({rom_addr, rom_sel, vga_x, vga_y, plot, busy, done, dbg_state} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: addr=%0d sel=%0d x=%0d y=%0d plot=%0d busy=%0d done=%0d st=%0d, all must be 0",
               rom_addr, rom_sel, vga_x, vga_y, plot, busy, done, dbg_state);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    seen_done = 0; seen_plot = 0;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (plot || busy) seen_plot++;
    end
    tests_run++;
    if (seen_done !== 0 || seen_plot !== 0) begin
      fails++; $display("FAIL midreset_quiet: got %0d done, %0d busy/plot cycles want 0, 0", seen_done, seen_plot);
    end
    // Restart with a stray start (mode 10) poked in mid-transfer.
    run_xfer(2'b00, 8'd10, 8'd20, -1, 30, 400);
    tests_run++;
    if (addr_c1 !== 15'd0 || first_x !== 10 || first_y !== FIRST_SY) begin
      fails++; $display("FAIL restart_first: got addr %0d (%0d,%0d) want 0 (10,%0d)", addr_c1, first_x, first_y, FIRST_SY);
    end
    tests_run++;
    if (n_plots !== SPR_PLOTS || done_cyc !== 194 || done_cnt !== 1) begin
      fails++; $display("FAIL busy_start_ignored: got %0d plots done@%0d x%0d want %0d done@194 x1", n_plots, done_cyc, done_cnt, SPR_PLOTS);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      fails++; $display("FAIL busy_start_queued: got busy=%0d st=%0d want 0 0", busy, dbg_state);
    end
  endtask

  // ---------------- sequence + report
  initial begin
    test_reset();
    test_sprite();
    test_erase();
    test_background();
    test_clip();
    test_reserved();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised pixel-stream sequencer between the game FSM and the VGA adapter. On a start pulse it walks a rectangular region, issues ROM addresses, and emits one plot strobe per visible pixel. Three modes: draw a sprite at (px,py), erase a sprite footprint by redrawing the matching background window, or redraw the full background. It adds a start/busy/done handshake, screen clipping and optional transparency to the earlier fixed-size draw logic.

## Interface
Parameters:
- SPR_W, 12, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- SCR_W, 160, screen width
- SCR_H, 120, screen height
- COORD_W, 8, coordinate width
- ADDR_W, 15, ROM address width
- COL_W, 3, colour width
- TRANSP_KEY, 3'b000, transparent colour (used only with the macro)

Ports:
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 sprite, 01 erase-footprint, 10 full background, 11 reserved
- px, py  in  COORD_W each  sprite top-left; latched at start
- rom_data  in  COL_W  colour from the selected ROM, 1-cycle synchronous latency
- rom_addr  out  ADDR_W  registered ROM address
- rom_sel  out  1  0 = sprite ROM, 1 = background ROM
- vga_x, vga_y  out  COORD_W each  pixel coordinate
- colour  out  COL_W  equals rom_data
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch mode, px and py; clear col and row; go to RUN. A start during RUN or DONE is ignored and not queued.
- RUN: one pixel per cycle. col counts 0..W-1 and wraps to 0 with row+1. The last pixel is (W-1, H-1). After the last pixel, go to DONE.
- DONE: lasts one cycle, then IDLE.
- Region size per mode:
  - sprite and erase: W=SPR_W, H=SPR_H
  - full background: W=SCR_W, H=SCR_H
- Pixel k = row*W+col. rom_addr per mode:
  - sprite: k
  - erase: (py+row)*SCR_W+(px+col)
  - full background: k
- rom_sel = 1 in erase and full background; 0 in sprite.
- Screen coordinates: sprite/erase use (px+col, py+row), computed COORD_W+1 bits wide. Full background uses (col, row).
- Clipping: if x ≥ SCR_W or y ≥ SCR_H (including carry out of COORD_W), plot is suppressed. Counters still advance, so the pixel count is unchanged.
- Mode 11: no plots; DONE is entered on the cycle after start.
- Reset, including mid-transfer: state IDLE; counters 0; rom_addr, rom_sel, vga_x, vga_y, plot, busy, done all 0. The transfer is abandoned and no done is issued.

## Timing
- Edge 0 samples start. rom_addr for pixel k is valid in cycle k+1.
- vga_x, vga_y and the plot qualifier for pixel k are registered one stage behind rom_addr, so they are valid in cycle k+2, aligned with rom_data. colour is a combinational passthrough of rom_data.
- N = W*H:
  - last plot in cycle N+1
  - done=1 in cycle N+2
  - busy high in cycles 1..N+1, low in the done cycle
- Next start is accepted in cycle N+3 at the earliest.
- Throughput is 1 pixel/clock. No stalls; the VGA adapter must accept plot every cycle.

## Configuration
- TRANSPARENCY_EN defined: in sprite mode, plot = plot_qualifier & (rom_data != TRANSP_KEY). Erase and background modes are unaffected.
- Not defined: every unclipped pixel plots, whatever its colour. TRANSP_KEY is unused.

## Test plan
- Sprite at (10,20), reset values: start pulse, mode 00 → 192 plots, first at (10,20) with rom_addr 0, last at (21,35) with rom_addr 191; done in cycle 194; busy high in cycles 1..193.
- Erase at (10,20): mode 01 → rom_sel=1, first rom_addr 3210, the row-1 first pixel has rom_addr 3370; 192 plots.
- Full background: mode 10 → 19200 plots covering (0,0)..(159,119); rom_addr 0..19199; done in cycle 19202.
- Clipping at (155,110): sprite mode → only x 155..159, y 110..119 plot (50 plots); done still in cycle 194.
- Transparency, macro on: sprite ROM holds 0 at addresses 0..11 → no plot on row 0; 180 plots. Macro off → 192 plots.
- Reset mid-transfer: resetn low at pixel 50 → all outputs 0 immediately; no done. A new start after release restarts from pixel 0. A start pulse while busy is ignored.
